debug_trace_pipe: RTL and testbench

DEBUG_TRACE_PIPE -- requirements
Module: debug_trace_pipe

---
 rtl/debug_trace_pipe.sv | 146 ++++++++++++++
 tb/tb_debug_trace_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_pipe.sv
// Debug trace pipeline: per-stage stall/flush shadow pipe whose
// last-stage retirements are queued in a trace FIFO with loss counting.
module debug_trace_pipe #(
    parameter int STAGES     = 3,
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [STAGES-1:0]     i_stall,
    input  logic [STAGES-1:0]     i_flush,
    input  logic                  i_dbgValid,
    input  logic [31:0]           i_dbgTick,
    input  logic [INST_WIDTH-1:0] i_dbgInst,
    input  logic [PC_WIDTH-1:0]   i_dbgPC,
    output logic [STAGES-1:0]     o_stageValid,
    output logic [31:0]           o_dbgTick,
    output logic [INST_WIDTH-1:0] o_dbgInst,
    output logic [PC_WIDTH-1:0]   o_dbgPC,
    output logic                  o_trcValid,
    input  logic                  i_trcReady,
    output logic [31:0]           o_trcTick,
    output logic [INST_WIDTH-1:0] o_trcInst,
    output logic [PC_WIDTH-1:0]   o_trcPC,
    output logic [CW-1:0]         o_trcCount,
    output logic [15:0]           o_trcLost,
    input  logic                  i_trcClear
);

    logic                  r_valid [STAGES];
    logic [31:0]           r_tick  [STAGES];
    logic [INST_WIDTH-1:0] r_inst  [STAGES];
    logic [PC_WIDTH-1:0]   r_pc    [STAGES];

    logic                  w_upValid [STAGES];
    logic [31:0]           w_upTick  [STAGES];
    logic [INST_WIDTH-1:0] w_upInst  [STAGES];
    logic [PC_WIDTH-1:0]   w_upPC    [STAGES];

    always_comb begin
        w_upValid[0] = i_dbgValid;
        w_upTick[0]  = i_dbgTick;
        w_upInst[0]  = i_dbgInst;
        w_upPC[0]    = i_dbgPC;
        for (int k = 1; k < STAGES; k++) begin
            w_upValid[k] = r_valid[k-1];
            w_upTick[k]  = r_tick[k-1];
            w_upInst[k]  = r_inst[k-1];
            w_upPC[k]    = r_pc[k-1];
        end
    end

    // Stall outranks flush; a flushed bubble keeps the upstream tick.
    always_ff @(posedge i_clock) begin
        for (int k = 0; k < STAGES; k++) begin
            if (i_reset) begin
                r_valid[k] <= 1'b0;
                r_tick[k]  <= '0;
                r_inst[k]  <= '0;
                r_pc[k]    <= '0;
            end else if (i_stall[k]) begin
                r_valid[k] <= r_valid[k];
            end else if (i_flush[k]) begin
                r_valid[k] <= 1'b0;
                r_tick[k]  <= w_upTick[k];
                r_inst[k]  <= '0;
                r_pc[k]    <= '0;
            end else begin
                r_valid[k] <= w_upValid[k];
                r_tick[k]  <= w_upTick[k];
                r_inst[k]  <= w_upInst[k];
                r_pc[k]    <= w_upPC[k];
            end
        end
    end

    always_comb begin
        o_stageValid = '0;
        for (int k = 0; k < STAGES; k++) begin
            o_stageValid[k] = r_valid[k];
        end
    end

    assign o_dbgTick = r_tick[STAGES-1];
    assign o_dbgInst = r_inst[STAGES-1];
    assign o_dbgPC   = r_pc[STAGES-1];

    logic [31:0]           r_memTick [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] r_memInst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   r_memPC   [FIFO_DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;
    logic [15:0]           r_lost;

    logic w_retire;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_retire = r_valid[STAGES-1] & ~i_stall[STAGES-1];
    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_pop    = (r_count != '0) & i_trcReady;
    assign w_push   = w_retire & (~w_full | w_pop);
    assign w_drop   = w_retire & w_full & ~w_pop;

    always_ff @(posedge i_clock) begin
        if (w_push && !i_reset) begin
            r_memTick[r_wrPtr] <= r_tick[STAGES-1];
            r_memInst[r_wrPtr] <= r_inst[STAGES-1];
            r_memPC[r_wrPtr]   <= r_pc[STAGES-1];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_lost  <= '0;
        end else begin
            if (w_push) r_wrPtr <= AW'(r_wrPtr + 1'b1);
            if (w_pop)  r_rdPtr <= AW'(r_rdPtr + 1'b1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            if (i_trcClear)
                r_lost <= w_drop ? 16'd1 : 16'd0;
            else if (w_drop && r_lost != 16'hFFFF)
                r_lost <= r_lost + 16'd1;
        end
    end

    assign o_trcValid = (r_count != '0);
    assign o_trcTick  = r_memTick[r_rdPtr];
    assign o_trcInst  = r_memInst[r_rdPtr];
    assign o_trcPC    = r_memPC[r_rdPtr];
    assign o_trcCount = r_count;
    assign o_trcLost  = r_lost;

endmodule

// File: tb/tb_debug_trace_pipe.sv
// Directed testbench for debug_trace_pipe (STAGES=3, FIFO_DEPTH=8).
module tb_debug_trace_pipe;

    localparam int S  = 3;
    localparam int PW = 32;
    localparam int IW = 32;
    localparam int FD = 8;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [S-1:0]  stall;
    logic [S-1:0]  flush;
    logic          dv;
    logic [31:0]   dtick;
    logic [IW-1:0] dinst;
    logic [PW-1:0] dpc;
    logic [S-1:0]  sv;
    logic [31:0]   otick;
    logic [IW-1:0] oinst;
    logic [PW-1:0] opc;
    logic          tvalid;
    logic          tready;
    logic [31:0]   ttick;
    logic [IW-1:0] tinst;
    logic [PW-1:0] tpc;
    logic [CW-1:0] tcount;
    logic [15:0]   tlost;
    logic          tclear;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_trace_pipe #(
        .STAGES(S), .PC_WIDTH(PW), .INST_WIDTH(IW), .FIFO_DEPTH(FD)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
        .i_dbgValid(dv), .i_dbgTick(dtick), .i_dbgInst(dinst),
        .i_dbgPC(dpc), .o_stageValid(sv), .o_dbgTick(otick),
        .o_dbgInst(oinst), .o_dbgPC(opc), .o_trcValid(tvalid),
        .i_trcReady(tready), .o_trcTick(ttick), .o_trcInst(tinst),
        .o_trcPC(tpc), .o_trcCount(tcount), .o_trcLost(tlost),
        .i_trcClear(tclear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic v, input int t);
        dv    = v;
        dtick = t;
        dinst = 32'hA000_0000 + t;
        dpc   = 32'h0000_1000 + 4 * t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        feed(1'b0, 0);
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stall = '0; flush = '0; tready = 0; tclear = 0;
        do_reset();
        checks++;
        if (sv !== 3'b000) begin
            errors++; $display("FAIL reset_sv got %b exp 000", sv);
        end
        checks++;
        if (tcount !== 0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo got cnt=%0d v=%b exp 0/0", tcount, tvalid);
        end
        checks++;
        if (tlost !== 0 || otick !== 0) begin
            errors++;
            $display("FAIL reset_lost got lost=%0d tick=%0d exp 0/0", tlost, otick);
        end
    endtask

    task automatic test_latency();
        do_reset();
        feed(1, 10); step();
        feed(1, 11); step();
        feed(1, 12); step();
        checks++;
        if (otick !== 10 || sv !== 3'b111) begin
            errors++;
            $display("FAIL latency got tick=%0d sv=%b exp 10/111", otick, sv);
        end
        feed(0, 0); step();
        checks++;
        if (tcount !== 1 || ttick !== 10 || tvalid !== 1'b1) begin
            errors++;
            $display("FAIL first_push got cnt=%0d head=%0d exp 1/10", tcount, ttick);
        end
        step(); step();
        checks++;
        if (tcount !== 3 || sv !== 3'b000) begin
            errors++;
            $display("FAIL drain got cnt=%0d sv=%b exp 3/000", tcount, sv);
        end
        tready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ttick !== 10 + i || tinst !== 32'hA000_0000 + 10 + i ||
                tpc !== 32'h1000 + 4 * (10 + i)) begin
                errors++;
                $display("FAIL head_order got %0d exp %0d", ttick, 10 + i);
            end
            step();
        end
        checks++;
        if (tcount !== 0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL empty got cnt=%0d v=%b exp 0/0", tcount, tvalid);
        end
        step();
        checks++;
        if (tcount !== 0) begin
            errors++; $display("FAIL empty_pop got cnt=%0d exp 0", tcount);
        end
        tready = 0;
    endtask

    task automatic test_stall_flush();
        do_reset();
        feed(1, 20); step();
        feed(1, 21); step();
        feed(1, 22);
        stall = 3'b010; flush = 3'b010;
        step();
        checks++;
        if (otick !== 20 || sv !== 3'b111) begin
            errors++;
            $display("FAIL stall_c1 got tick=%0d sv=%b exp 20/111", otick, sv);
        end
        step();
        checks++;
        if (otick !== 20 || sv[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_c2 got tick=%0d sv1=%b exp 20/1", otick, sv[1]);
        end
        stall = '0; flush = '0;
        feed(0, 0);
        step(); step();
        checks++;
        if (otick !== 22) begin
            errors++; $display("FAIL stall_release got %0d exp 22", otick);
        end
    endtask

    task automatic test_flush();
        do_reset();
        dv = 1; dtick = 42; dinst = 32'h1234; dpc = 32'h55;
        flush = 3'b001;
        step();
        flush = '0;
        checks++;
        if (sv !== 3'b000) begin
            errors++; $display("FAIL flush_s0 got sv=%b exp 000", sv);
        end
        feed(0, 0);
        step(); step();
        checks++;
        if (otick !== 42 || oinst !== 0 || opc !== 0 || sv !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble got tick=%0d inst=%h pc=%h exp 42/0/0",
                     otick, oinst, opc);
        end
        step();
        checks++;
        if (tcount !== 0) begin
            errors++; $display("FAIL flush_nopush got cnt=%0d exp 0", tcount);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            feed(1, 100 + i); step();
        end
        feed(0, 0);
        step(); step(); step();
        checks++;
        if (tcount !== 8 || tlost !== 2) begin
            errors++;
            $display("FAIL overflow got cnt=%0d lost=%0d exp 8/2", tcount, tlost);
        end
        checks++;
        if (ttick !== 100) begin
            errors++; $display("FAIL overflow_head got %0d exp 100", ttick);
        end
        tclear = 1; step(); tclear = 0;
        checks++;
        if (tlost !== 0) begin
            errors++; $display("FAIL clear got %0d exp 0", tlost);
        end
    endtask

    task automatic test_back_to_back();
        feed(1, 200); step();
        feed(0, 0); step(); step();
        tready = 1; step(); tready = 0;
        checks++;
        if (tcount !== 8 || tlost !== 0 || ttick !== 101) begin
            errors++;
            $display("FAIL full_pop got cnt=%0d lost=%0d head=%0d exp 8/0/101",
                     tcount, tlost, ttick);
        end
        feed(1, 201); step();
        feed(0, 0); step(); step();
        tclear = 1; step(); tclear = 0;
        checks++;
        if (tlost !== 1 || tcount !== 8) begin
            errors++;
            $display("FAIL clear_drop got lost=%0d cnt=%0d exp 1/8", tlost, tcount);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            feed(1, 300 + i); step();
        end
        feed(0, 0); step();
        checks++;
        if (tcount !== 5 || sv !== 3'b110) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d sv=%b exp 5/110", tcount, sv);
        end
        rst = 1; step(); rst = 0;
        checks++;
        if (sv !== 3'b000 || tcount !== 0 || tlost !== 0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got sv=%b cnt=%0d lost=%0d exp 000/0/0",
                     sv, tcount, tlost);
        end
        step(); step(); step();
        checks++;
        if (tcount !== 0) begin
            errors++; $display("FAIL post_reset got cnt=%0d exp 0", tcount);
        end
    endtask

    initial begin
        rst = 1; stall = '0; flush = '0; tready = 0; tclear = 0;
        feed(0, 0);
        test_reset();
        test_latency();
        test_stall_flush();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
